// File: rtl/readout_buffer_scheduler.sv
// Arbitrates the single result buffer between the compute writer and the SPI read controller.
// Registered FSM: IDLE -> FILL -> READY -> READOUT -> IDLE. RAM port signals are muxed from the state.
module readout_buffer_scheduler #(
   parameter int AW    = 6,
   parameter int DW    = 8,
   parameter int DEPTH = 37
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          iCLR,
   input  logic          iWR_REQ,
   output logic          oWR_GNT,
   input  logic          iWR_EN,
   input  logic [AW-1:0] iWR_ADDR,
   input  logic [DW-1:0] iWR_DATA,
   input  logic          iWR_DONE,
   input  logic          iCS_ACT,
   output logic          oRd_CTRL_EN,
   output logic          oRd_CTRL_CLR,
   input  logic          iRd_EN,
   input  logic [AW-1:0] iRd_ADDR,
   input  logic          iRd_DONE,
   output logic          oMEM_EN,
   output logic          oMEM_WE,
   output logic [AW-1:0] oMEM_ADDR,
   output logic [DW-1:0] oMEM_WDATA,
   output logic          oREADY,
   output logic          oOVR,
   output logic          oADDR_ERR,
   output logic [7:0]    oFRAME_CNT
);

   typedef enum logic [1:0] {IDLE, FILL, READY, READOUT} state_t;

   state_t     r_state, w_nxt;
   logic       r_clr_pls;
   logic       r_ovr;
   logic       r_addr_err;
   logic [7:0] r_frame_cnt;
   logic       w_addr_ok;
   logic       w_clr_evt;

   assign w_addr_ok = (iWR_ADDR <= AW'(DEPTH - 1));

   // Abort (READOUT->READY) is both an exit and an entry but yields a single pulse.
   assign w_clr_evt = ((w_nxt == READY) && (r_state != READY)) ||
                      ((r_state == READOUT) && (w_nxt != READOUT));

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_state     <= IDLE;
         r_clr_pls   <= 1'b0;
         r_ovr       <= 1'b0;
         r_addr_err  <= 1'b0;
         r_frame_cnt <= 8'd0;
      end else if (iCLR) begin
         r_state     <= IDLE;
         r_clr_pls   <= 1'b0;
         r_ovr       <= 1'b0;
         r_addr_err  <= 1'b0;
         r_frame_cnt <= 8'd0;
      end else begin
         r_state   <= w_nxt;
         r_clr_pls <= w_clr_evt;
         if (iWR_REQ && ((r_state == READY) || (r_state == READOUT)))
            r_ovr <= 1'b1;
         if ((r_state == FILL) && iWR_EN && !w_addr_ok)
            r_addr_err <= 1'b1;
         if ((r_state == READOUT) && iRd_DONE)
            r_frame_cnt <= r_frame_cnt + 8'd1;
      end
   end

   always_comb begin
      w_nxt       = r_state;
      oWR_GNT     = 1'b0;
      oREADY      = 1'b0;
      oRd_CTRL_EN = 1'b0;
      oMEM_EN     = 1'b0;
      oMEM_WE     = 1'b0;
      oMEM_ADDR   = '0;
      oMEM_WDATA  = '0;
      case (r_state)
         IDLE: begin
            if (iWR_REQ) w_nxt = FILL;
         end
         FILL: begin
            oWR_GNT    = 1'b1;
            oMEM_EN    = iWR_EN & w_addr_ok;
            oMEM_WE    = iWR_EN & w_addr_ok;
            oMEM_ADDR  = iWR_ADDR;
            oMEM_WDATA = iWR_DATA;
            if (iWR_DONE) w_nxt = READY;
         end
         READY: begin
            oREADY = 1'b1;
            if (iCS_ACT) w_nxt = READOUT;
         end
         READOUT: begin
            oRd_CTRL_EN = iCS_ACT;
            oMEM_EN     = iRd_EN;
            oMEM_ADDR   = iRd_ADDR;
            // Done wins over a simultaneous chip-select drop.
            if (iRd_DONE)      w_nxt = IDLE;
            else if (!iCS_ACT) w_nxt = READY;
         end
         default: w_nxt = IDLE;
      endcase
   end

   assign oRd_CTRL_CLR = iRST | iCLR | r_clr_pls;
   assign oOVR         = r_ovr;
   assign oADDR_ERR    = r_addr_err;
   assign oFRAME_CNT   = r_frame_cnt;

endmodule

// File: tb/tb_readout_buffer_scheduler.sv
// Self-checking bench: behavioural RAM plus a scoreboard of expected read bytes,
// driven through full frames, aborts, overrun, bad addresses, async reset and counter wrap.
module tb_readout_buffer_scheduler;
   localparam int AW = 6;
   localparam int DW = 8;
   localparam int DEPTH = 37;

   logic          iCLK = 1'b0;
   logic          iRST, iCLR, iWR_REQ, iWR_EN, iWR_DONE, iCS_ACT, iRd_EN, iRd_DONE;
   logic [AW-1:0] iWR_ADDR, iRd_ADDR;
   logic [DW-1:0] iWR_DATA;
   logic          oWR_GNT, oRd_CTRL_EN, oRd_CTRL_CLR, oMEM_EN, oMEM_WE;
   logic [AW-1:0] oMEM_ADDR;
   logic [DW-1:0] oMEM_WDATA;
   logic          oREADY, oOVR, oADDR_ERR;
   logic [7:0]    oFRAME_CNT;

   always #5 iCLK = ~iCLK;

   readout_buffer_scheduler #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .iCLK(iCLK), .iRST(iRST), .iCLR(iCLR),
      .iWR_REQ(iWR_REQ), .oWR_GNT(oWR_GNT), .iWR_EN(iWR_EN), .iWR_ADDR(iWR_ADDR),
      .iWR_DATA(iWR_DATA), .iWR_DONE(iWR_DONE), .iCS_ACT(iCS_ACT),
      .oRd_CTRL_EN(oRd_CTRL_EN), .oRd_CTRL_CLR(oRd_CTRL_CLR),
      .iRd_EN(iRd_EN), .iRd_ADDR(iRd_ADDR), .iRd_DONE(iRd_DONE),
      .oMEM_EN(oMEM_EN), .oMEM_WE(oMEM_WE), .oMEM_ADDR(oMEM_ADDR), .oMEM_WDATA(oMEM_WDATA),
      .oREADY(oREADY), .oOVR(oOVR), .oADDR_ERR(oADDR_ERR), .oFRAME_CNT(oFRAME_CNT)
   );

   logic [DW-1:0] ram [64];
   logic [DW-1:0] ram_q;
   logic          ram_vld = 1'b0;
   logic [DW-1:0] shadow [DEPTH];
   logic [DW-1:0] sb_q [$];
   int            n_chk = 0;
   int            n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One-cycle read latency RAM.
   always @(posedge iCLK) begin
      ram_vld <= oMEM_EN & ~oMEM_WE;
      if (oMEM_EN) begin
         if (oMEM_WE) ram[oMEM_ADDR] <= oMEM_WDATA;
         else         ram_q <= ram[oMEM_ADDR];
      end
   end

   always @(negedge iCLK) begin
      if (ram_vld) begin
         if (sb_q.size() == 0) chk("rd_unexpected", 32'(sb_q.size()), 1);
         else                  chk("rd_data", ram_q, sb_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic wr_frame(input logic [7:0] xo);
      iWR_REQ = 1'b1;
      tick();
      chk("gnt_fill", oWR_GNT, 1);
      iWR_REQ = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         iWR_EN   = 1'b1;
         iWR_ADDR = AW'(a);
         iWR_DATA = a[7:0] ^ xo;
         iWR_DONE = (a == DEPTH - 1);
         shadow[a] = a[7:0] ^ xo;
         #1;
         if (a == 5) begin
            chk("wr_we", oMEM_WE, 1);
            chk("wr_addr", oMEM_ADDR, 5);
         end
         tick();
      end
      iWR_EN = 1'b0;
      iWR_DONE = 1'b0;
      #1;
      chk("ready_set", oREADY, 1);
      chk("clr_on_ready", oRd_CTRL_CLR, 1);
      chk("gnt_off", oWR_GNT, 0);
   endtask

   task automatic rd_start();
      iCS_ACT = 1'b1;
      tick();
      chk("ready_clr_in_rdout", oREADY, 0);
      chk("rdctrl_en", oRd_CTRL_EN, 1);
      chk("clr_low_rdout", oRd_CTRL_CLR, 0);
   endtask

   task automatic fetch(input int a0, input int n);
      for (int i = 0; i < n; i++) begin
         iRd_EN   = 1'b1;
         iRd_ADDR = AW'(a0 + i);
         sb_q.push_back(shadow[a0 + i]);
         tick();
      end
      iRd_EN = 1'b0;
   endtask

   task automatic rd_finish(input logic [7:0] exp_cnt);
      iRd_DONE = 1'b1;
      tick();
      iRd_DONE = 1'b0;
      iCS_ACT  = 1'b0;
      #1;
      chk("frame_cnt", oFRAME_CNT, exp_cnt);
      chk("clr_on_exit", oRd_CTRL_CLR, 1);
      chk("idle_ready", oREADY, 0);
      chk("idle_rden", oRd_CTRL_EN, 0);
      tick();
      chk("clr_one_cycle", oRd_CTRL_CLR, 0);
      chk("idle_gnt", oWR_GNT, 0);
   endtask

   logic [DW-1:0] b40;

   initial begin
      iRST = 1'b1; iCLR = 1'b0; iWR_REQ = 1'b0; iWR_EN = 1'b0; iWR_DONE = 1'b0;
      iCS_ACT = 1'b0; iRd_EN = 1'b0; iRd_DONE = 1'b0;
      iWR_ADDR = '0; iRd_ADDR = '0; iWR_DATA = '0;
      #2;
      chk("rst_gnt", oWR_GNT, 0);
      chk("rst_clr", oRd_CTRL_CLR, 1);
      chk("rst_ready", oREADY, 0);
      chk("rst_cnt", oFRAME_CNT, 0);
      chk("rst_memen", oMEM_EN, 0);
      tick(); tick();
      iRST = 1'b0;
      tick();
      chk("post_rst_clr", oRd_CTRL_CLR, 0);

      // T1 full frame
      wr_frame(8'h00);
      rd_start();
      fetch(0, DEPTH);
      rd_finish(8'd1);

      // T2 abort after 10 fetches, then a full re-read
      wr_frame(8'hA5);
      rd_start();
      fetch(0, 10);
      iCS_ACT = 1'b0;
      tick();
      chk("abort_clr", oRd_CTRL_CLR, 1);
      chk("abort_ready", oREADY, 1);
      chk("abort_rden", oRd_CTRL_EN, 0);
      tick();
      chk("abort_clr_once", oRd_CTRL_CLR, 0);
      chk("abort_ready_hold", oREADY, 1);
      rd_start();
      fetch(0, DEPTH);
      rd_finish(8'd2);

      // T3 overrun during readout
      wr_frame(8'h3C);
      rd_start();
      fetch(0, 20);
      iWR_REQ = 1'b1;
      tick();
      chk("ovr_set", oOVR, 1);
      chk("ovr_no_gnt", oWR_GNT, 0);
      fetch(20, DEPTH - 20);
      chk("ovr_no_gnt2", oWR_GNT, 0);
      iRd_DONE = 1'b1;
      tick();
      iRd_DONE = 1'b0;
      iCS_ACT  = 1'b0;
      chk("ovr_idle_gnt", oWR_GNT, 0);
      chk("ovr_cnt", oFRAME_CNT, 3);
      tick();
      chk("ovr_late_gnt", oWR_GNT, 1);
      iWR_REQ = 1'b0;

      // T4 bad address in FILL
      b40 = ram[40];
      iWR_EN = 1'b1; iWR_ADDR = 6'd40; iWR_DATA = 8'h77;
      #1;
      chk("bad_we", oMEM_WE, 0);
      chk("bad_en", oMEM_EN, 0);
      tick();
      chk("addr_err", oADDR_ERR, 1);
      chk("ram40_kept", ram[40], b40);
      chk("ovr_sticky", oOVR, 1);
      iWR_ADDR = 6'd3; iWR_DATA = 8'h5A;
      #1;
      chk("fill_we_pre_rst", oMEM_WE, 1);

      // T5a async reset mid-FILL
      iRST = 1'b1;
      #1;
      chk("arst_fill_gnt", oWR_GNT, 0);
      chk("arst_fill_we", oMEM_WE, 0);
      chk("arst_fill_clr", oRd_CTRL_CLR, 1);
      chk("arst_fill_ovr", oOVR, 0);
      chk("arst_fill_aerr", oADDR_ERR, 0);
      chk("arst_fill_cnt", oFRAME_CNT, 0);
      iWR_EN = 1'b0;
      tick();
      iRST = 1'b0;
      tick();
      chk("arst_fill_idle", oWR_GNT, 0);
      chk("arst_fill_idle_rdy", oREADY, 0);

      // T5b async reset mid-READOUT
      wr_frame(8'h11);
      rd_start();
      fetch(0, 5);
      iRd_EN = 1'b1; iRd_ADDR = 6'd5;
      #1;
      chk("rdout_memen_pre_rst", oMEM_EN, 1);
      iRST = 1'b1;
      #1;
      chk("arst_rd_memen", oMEM_EN, 0);
      chk("arst_rd_en", oRd_CTRL_EN, 0);
      chk("arst_rd_clr", oRd_CTRL_CLR, 1);
      iRd_EN = 1'b0; iCS_ACT = 1'b0;
      tick();
      iRST = 1'b0;
      tick();
      chk("arst_rd_idle_rdy", oREADY, 0);
      chk("arst_rd_idle_gnt", oWR_GNT, 0);

      // T6 256 short frames; odd ones drop CS together with done
      for (int f = 0; f < 256; f++) begin
         iWR_REQ = 1'b1;
         tick();
         iWR_REQ = 1'b0; iWR_DONE = 1'b1;
         tick();
         iWR_DONE = 1'b0; iCS_ACT = 1'b1;
         tick();
         iRd_DONE = 1'b1;
         if (f % 2 == 1) iCS_ACT = 1'b0;
         tick();
         iRd_DONE = 1'b0; iCS_ACT = 1'b0;
         if (f == 1)   chk("cnt_cs_fall_done", oFRAME_CNT, 2);
         if (f == 254) chk("cnt_255", oFRAME_CNT, 255);
      end
      chk("cnt_wrap", oFRAME_CNT, 0);

      // synchronous clear
      iWR_REQ = 1'b1;
      tick();
      iWR_REQ = 1'b0;
      iCLR = 1'b1;
      #1;
      chk("sclr_clr", oRd_CTRL_CLR, 1);
      tick();
      iCLR = 1'b0;
      #1;
      chk("sclr_idle", oWR_GNT, 0);

      tick();
      chk("sb_drain", 32'(sb_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
